// File: rtl/camera_pkg.sv
// Shared types and constants for the camera init sequencer and its ROM.
package camera_pkg;

  localparam int unsigned CNT_W         = 17;
  localparam int unsigned CYCLES_PER_MS = 100;
  localparam int unsigned ROM_DEPTH     = 32;

  localparam logic [7:0] DELAY_MARK_DEF = 8'hFF;
  localparam logic [6:0] SLAVE_ADDR_DEF = 7'h21;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_DELAY,
    ST_GAP,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] val;
  } rom_entry_t;

  // Counter preload for a delay entry of 'ms' milliseconds; 0 ms still costs one cycle.
  function automatic logic [CNT_W-1:0] delay_load(input logic [7:0] ms);
    logic [CNT_W-1:0] cycles;
    cycles = CNT_W'(ms) * CNT_W'(CYCLES_PER_MS);
    return (ms == 8'd0) ? '0 : cycles - CNT_W'(1);
  endfunction

endpackage

// File: rtl/camera_init_rom.sv
// Constant camera register table: idx -> {reg_addr, value}.
// Indices at or beyond NUM_ENTRIES read back as a zero-length delay entry.
module camera_init_rom
  import camera_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 32
) (
  input  logic [7:0] idx,
  output logic [7:0] addr_c,
  output logic [7:0] val_c
);

  rom_entry_t entry;

  always_comb begin
    entry = '{addr: DELAY_MARK_DEF, val: 8'h00};
    if (32'(idx) < NUM_ENTRIES) begin
      case (idx)
        8'd0:    entry = 16'h1280;  // COM7 soft reset
        8'd1:    entry = 16'h1101;
        8'd2:    entry = 16'hFF02;  // settle 2 ms after reset
        8'd3:    entry = 16'h6B4A;
        8'd4:    entry = 16'h1204;
        8'd5:    entry = 16'h0C00;
        8'd6:    entry = 16'h3E00;
        8'd7:    entry = 16'h40D0;
        8'd8:    entry = 16'h8C00;
        8'd9:    entry = 16'h0400;
        8'd10:   entry = 16'h3A04;
        8'd11:   entry = 16'h1418;
        8'd12:   entry = 16'h4FB3;
        8'd13:   entry = 16'h50B3;
        8'd14:   entry = 16'h5100;
        8'd15:   entry = 16'h523D;
        8'd16:   entry = 16'h53A7;
        8'd17:   entry = 16'h54E4;
        8'd18:   entry = 16'h589E;
        8'd19:   entry = 16'h3DC0;
        8'd20:   entry = 16'h1714;
        8'd21:   entry = 16'h1802;
        8'd22:   entry = 16'h3280;
        8'd23:   entry = 16'h1903;
        8'd24:   entry = 16'h1A7B;
        8'd25:   entry = 16'h030A;
        8'd26:   entry = 16'h0F41;
        8'd27:   entry = 16'h1E00;
        8'd28:   entry = 16'h330B;
        8'd29:   entry = 16'h3C78;
        8'd30:   entry = 16'h6900;
        8'd31:   entry = 16'h7400;
        default: entry = '{addr: DELAY_MARK_DEF, val: 8'h00};
      endcase
    end
  end

  assign addr_c = entry.addr;
  assign val_c  = entry.val;

endmodule

// File: rtl/camera_init_sequencer.sv
// Walks the camera init table and issues one SCCB transaction per entry.
// Define CAMERA_INIT_READBACK_EN to read back and verify every written register.
module camera_init_sequencer
  import camera_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR     = SLAVE_ADDR_DEF,
  parameter int unsigned NUM_ENTRIES    = 32,
  parameter int unsigned POWERUP_CYCLES = 100,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [7:0]  DELAY_MARK     = DELAY_MARK_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       go,
  input  logic       sccb_done,
  input  logic [7:0] sccb_data_in,
  output logic       sccb_start,
  output logic [6:0] slave_addr,
  output logic [7:0] reg_addr,
  output logic [7:0] data,
  output logic       rw,
  output logic       busy,
  output logic       init_done,
  output logic       error,
  output logic [7:0] entry_idx
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       rom_addr_c;
  logic [7:0]       rom_val_c;
  logic             rd_ok_c;

  camera_init_rom #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_rom (
    .idx    (entry_idx),
    .addr_c (rom_addr_c),
    .val_c  (rom_val_c)
  );

`ifdef CAMERA_INIT_READBACK_EN
  // A write completion is always fine; a read must return what was written.
  assign rd_ok_c = !rw || (sccb_data_in == data);
`else
  logic unused_data_in;
  assign unused_data_in = ^sccb_data_in;
  assign rd_ok_c        = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sccb_start <= 1'b0;
      slave_addr <= SLAVE_ADDR;
      reg_addr   <= '0;
      data       <= '0;
      rw         <= 1'b0;
      busy       <= 1'b0;
      init_done  <= 1'b0;
      error      <= 1'b0;
      entry_idx  <= '0;
    end else begin
      sccb_start <= 1'b0;
      slave_addr <= SLAVE_ADDR;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (go) begin
            state     <= ST_PWRUP;
            cnt       <= CNT_W'(POWERUP_CYCLES - 1);
            entry_idx <= '0;
            busy      <= 1'b1;
            init_done <= 1'b0;
            error     <= 1'b0;
          end
        end
        ST_PWRUP: begin
          if (cnt == '0) state <= ST_FETCH;
          else           cnt   <= cnt - CNT_W'(1);
        end
        ST_FETCH: begin
          reg_addr <= rom_addr_c;
          data     <= rom_val_c;
          rw       <= 1'b0;
          if (rom_addr_c == DELAY_MARK) begin
            state <= ST_DELAY;
            cnt   <= delay_load(rom_val_c);
          end else begin
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          sccb_start <= 1'b1;
          cnt        <= CNT_W'(TIMEOUT_CYCLES - 1);
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          // done wins over an expiring timeout in the same cycle
          if (sccb_done && rd_ok_c) begin
            state <= ST_GAP;
            cnt   <= CNT_W'(GAP_CYCLES - 1);
          end else if (sccb_done || cnt == '0) begin
            state <= ST_ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DELAY: begin
          if (cnt == '0) state <= ST_NEXT;
          else           cnt   <= cnt - CNT_W'(1);
        end
        ST_GAP: begin
          if (cnt == '0) begin
`ifdef CAMERA_INIT_READBACK_EN
            if (!rw) begin
              rw    <= 1'b1;
              state <= ST_ISSUE;
            end else begin
              rw    <= 1'b0;
              state <= ST_NEXT;
            end
`else
            state <= ST_NEXT;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_NEXT: begin
          if (entry_idx == 8'(NUM_ENTRIES - 1)) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            init_done <= 1'b1;
          end else begin
            entry_idx <= entry_idx + 8'd1;
            state     <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
